// File: rtl/iob_ibus_dbus_merge.sv
// Two-master (ibus = 0, dbus = 1) to one-slave IOb merger with grant lock and read-owner FIFO.
// Optional build macro IOB_MERGE_RR_EN selects round-robin arbitration instead of fixed dbus priority.
module iob_ibus_dbus_merge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int OUTST_W = 1,
  parameter int WSTRB_W = DATA_W / 8,
  parameter int REQ_W   = 1 + ADDR_W + DATA_W + WSTRB_W,
  parameter int RESP_W  = DATA_W + 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic [REQ_W-1:0]  ibus_req,
  output logic [RESP_W-1:0] ibus_resp,
  input  logic [REQ_W-1:0]  dbus_req,
  output logic [RESP_W-1:0] dbus_resp,
  output logic [REQ_W-1:0]  mem_req,
  input  logic [RESP_W-1:0] mem_resp,
  output logic              err_o
);

  // Request layout {avalid, address, wdata, wstrb}; response layout {rdata, rvalid, ready}.
  localparam int DEPTH = 2 ** OUTST_W;
  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       LOCK     = 1'b1;
  localparam logic [OUTST_W-1:0] PTR_ONE  = OUTST_W'(1);
  localparam logic [OUTST_W:0]   CNT_ONE  = (OUTST_W + 1)'(1);
  localparam logic [OUTST_W:0]   CNT_FULL = (OUTST_W + 1)'(DEPTH);

  logic [0:0]         state_q, state_d;
  logic               grant_q, grant_d;
  logic [OUTST_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OUTST_W:0]   count_q, count_d;
  logic [DEPTH-1:0]   owner_q;
  logic               err_q, err_d;

  logic               i_av, d_av, winner, sel;
  logic [REQ_W-1:0]   sel_req;
  logic               sel_av, sel_read, mem_av, accept;
  logic               mem_ready, mem_rvalid;
  logic [DATA_W-1:0]  mem_rdata;
  logic               empty, full, head, push, pop;

  assign i_av       = ibus_req[REQ_W-1];
  assign d_av       = dbus_req[REQ_W-1];
  assign mem_ready  = mem_resp[0];
  assign mem_rvalid = mem_resp[1];
  assign mem_rdata  = mem_resp[RESP_W-1:2];

`ifdef IOB_MERGE_RR_EN
  logic last_q;
  // On contention the master that did not win last time is picked.
  assign winner = d_av & (~i_av | ~last_q);
`else
  assign winner = d_av;
`endif

  assign sel      = (state_q == LOCK) ? grant_q : winner;
  assign sel_req  = sel ? dbus_req : ibus_req;
  assign sel_av   = sel_req[REQ_W-1];
  assign sel_read = (sel_req[WSTRB_W-1:0] == '0);

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign head  = owner_q[rptr_q];

  // Full blocks reads regardless of a same-cycle pop, so avalid never depends on rvalid.
  assign mem_av  = sel_av & ~(sel_read & full);
  assign mem_req = {mem_av, sel_req[REQ_W-2:0]};
  assign accept  = mem_av & mem_ready;
  assign push    = accept & sel_read;
  assign pop     = mem_rvalid & ~empty;

  assign ibus_resp = {(pop & ~head) ? mem_rdata : '0, pop & ~head, accept & ~sel};
  assign dbus_resp = {(pop &  head) ? mem_rdata : '0, pop &  head, accept &  sel};
  assign err_o     = err_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    if (state_q == IDLE) begin
      if (sel_av && !accept) begin
        state_d = LOCK;
        grant_d = sel;
      end
    end else if (accept) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_ONE : rptr_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
    err_d = err_q | (mem_rvalid & empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      grant_q <= grant_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (push) owner_q[wptr_q] <= sel;
    end
  end

`ifdef IOB_MERGE_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                last_q <= 1'b0;
    else if (cke_i && accept) last_q <= sel;
  end
`endif

endmodule
